// File: rtl/uart_dec_sender.sv
// Binary-to-decimal ASCII frame sender for the UART console path.
// Double-dabble conversion, then digits MSD first plus a line terminator.
// Ports: clk, rstn (async, active-low), start/value (request),
//   busy/done/ovf (status), tx_data/tx_start/tx_done (UART byte handshake).
// Optional: define LEAD_ZERO_BLANK_EN to suppress leading zero digits.
module uart_dec_sender #(
   parameter int DATA_W  = 12,
   parameter int DIGITS  = 4,
   parameter bit TERM_CR = 1'b0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [DATA_W-1:0] value,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_done
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      IDLE, CONV, LOAD, WAIT, TERM, TWAIT
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] bin;
   logic [BW-1:0]     bcd;
   logic [BW-1:0]     bcd_adj;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [3:0]        nib;
`ifdef LEAD_ZERO_BLANK_EN
   logic              lead;
`endif

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign nib = bcd[4*idx +: 4];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
         lead     <= 1'b0;
`endif
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin   <= value;
                  bcd   <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= CONV;
`ifdef LEAD_ZERO_BLANK_EN
                  lead  <= 1'b1;
`endif
               end
            end
            CONV: begin
               bcd <= {bcd_adj[BW-2:0], bin[DATA_W-1]};
               bin <= bin << 1;
               // a carry out of the top digit means value >= 10^DIGITS
               if (bcd_adj[BW-1])
                  ovf <= 1'b1;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(DATA_W - 1)) begin
                  idx   <= IW'(DIGITS - 1);
                  state <= LOAD;
               end
            end
            LOAD: begin
`ifdef LEAD_ZERO_BLANK_EN
               // skip leading zeros, but the last digit is always sent
               if (lead && nib == 4'd0 && idx != '0) begin
                  idx <= idx - 1'b1;
               end else begin
                  lead     <= 1'b0;
                  tx_data  <= 8'h30 + {4'h0, nib};
                  tx_start <= 1'b1;
                  state    <= WAIT;
               end
`else
               tx_data  <= 8'h30 + {4'h0, nib};
               tx_start <= 1'b1;
               state    <= WAIT;
`endif
            end
            WAIT: begin
               if (tx_done) begin
                  if (idx != '0) begin
                     idx   <= idx - 1'b1;
                     state <= LOAD;
                  end else begin
                     state <= TERM;
                  end
               end
            end
            TERM: begin
               // CR goes first when enabled; tx_data tells which one is next
               if (TERM_CR && tx_data != 8'h0D)
                  tx_data <= 8'h0D;
               else
                  tx_data <= 8'h0A;
               tx_start <= 1'b1;
               state    <= TWAIT;
            end
            TWAIT: begin
               if (tx_done) begin
                  if (tx_data == 8'h0A) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= TERM;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_dec_sender.sv
// Directed bench for uart_dec_sender: two instances
// (12b/4d/LF and 16b/4d/CRLF) with a behavioural UART byte sink.
module tb_uart_dec_sender;

   typedef struct {
      string nm;
      int    inst;
      int    val;
      int    dly;
      bit    lat;
      bit    inj;
      string s;
      bit    ovf;
   } vec_t;

   logic        clk;
   logic        rstn;
   logic        st0, st1;
   logic [11:0] v0;
   logic [15:0] v1;
   logic        bsy [2];
   logic        dn  [2];
   logic        ov  [2];
   logic        txs [2];
   logic [7:0]  txd [2];
   logic        txdn[2];
   logic        spur[2];

   int          dly;
   int          nchk = 0;
   int          nfail = 0;
   logic [7:0]  rx[2][16];
   int          rxn[2] = '{0, 0};
   int          stab_err[2] = '{0, 0};

   uart_dec_sender #(.DATA_W(12), .DIGITS(4), .TERM_CR(1'b0)) dut0 (
      .clk(clk), .rstn(rstn), .start(st0), .value(v0),
      .busy(bsy[0]), .done(dn[0]), .ovf(ov[0]),
      .tx_data(txd[0]), .tx_start(txs[0]),
      .tx_done(txdn[0] | spur[0])
   );

   uart_dec_sender #(.DATA_W(16), .DIGITS(4), .TERM_CR(1'b1)) dut1 (
      .clk(clk), .rstn(rstn), .start(st1), .value(v1),
      .busy(bsy[1]), .done(dn[1]), .ovf(ov[1]),
      .tx_data(txd[1]), .tx_start(txs[1]),
      .tx_done(txdn[1] | spur[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar k = 0; k < 2; k++) begin : g_uart
      logic tdn;
      assign txdn[k] = tdn;
      initial begin
         logic [7:0] b;
         bit         ab;
         tdn = 1'b0;
         forever begin
            @(posedge clk); #1;
            if (rstn && txs[k]) begin
               b  = txd[k];
               ab = 1'b0;
               rx[k][rxn[k] % 16] = b;
               rxn[k]++;
               for (int i = 0; i < dly; i++) begin
                  @(posedge clk); #1;
                  if (!rstn)
                     ab = 1'b1;
                  else if (!ab && (txd[k] !== b || txs[k] !== 1'b0))
                     stab_err[k]++;
               end
               tdn = 1'b1;
               @(posedge clk); #1;
               tdn = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int k, input bit s, input int x);
      if (k == 0) begin
         st0 = s;
         v0  = 12'(x);
      end else begin
         st1 = s;
         v1  = 16'(x);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic vec_t mkv(input string nm, input int k, input int v,
                                input int d, input bit lat, input bit inj,
                                input string s, input bit o);
      vec_t r;
      r.nm = nm; r.inst = k; r.val = v; r.dly = d;
      r.lat = lat; r.inj = inj; r.s = s; r.ovf = o;
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input bit pre,
                          input bit chain, input int cval);
      int k, n, lat, b0, s0;
      bit fin, seen;
      k   = v.inst;
      lat = (k == 0 ? 12 : 16) + 2;
      b0  = rxn[k];
      s0  = stab_err[k];
      dly = v.dly;
      if (!pre) begin
         drive(k, 1'b1, v.val);
         tick();
         drive(k, 1'b0, 0);
      end
      n = 1;
      fin = 1'b0;
      seen = 1'b0;
      chk({v.nm, "_busy_rise"}, 32'(bsy[k]), 1);
      while (!fin && n < 3000) begin
         if (txs[k] && !seen) begin
            seen = 1'b1;
            if (v.lat)
               chk({v.nm, "_latency"}, n, lat);
         end
         if (dn[k]) begin
            fin = 1'b1;
            chk({v.nm, "_busy_done"}, 32'(bsy[k]), 0);
            if (chain)
               drive(k, 1'b1, cval);
         end else begin
            if (v.inj && n == lat + 3)
               drive(k, 1'b1, 50000);
            else
               drive(k, 1'b0, 0);
            tick();
            n++;
         end
      end
      chk({v.nm, "_finished"}, 32'(fin), 1);
      tick();
      drive(k, 1'b0, 0);
      chk({v.nm, "_done_once"}, 32'(dn[k]), 0);
      chk({v.nm, "_busy_after"}, 32'(bsy[k]), 32'(chain));
      chk({v.nm, "_nbytes"}, rxn[k] - b0, v.s.len());
      for (int i = 0; i < v.s.len(); i++)
         chk($sformatf("%s_byte%0d", v.nm, i),
             32'(rx[k][(b0 + i) % 16]), 32'(v.s[i]));
      chk({v.nm, "_ovf"}, 32'(ov[k]), 32'(v.ovf));
      chk({v.nm, "_stable"}, stab_err[k] - s0, 0);
   endtask

   task automatic chk_reset(input string nm, input int k);
      chk({nm, "_busy"}, 32'(bsy[k]), 0);
      chk({nm, "_done"}, 32'(dn[k]), 0);
      chk({nm, "_ovf"}, 32'(ov[k]), 0);
      chk({nm, "_txs"}, 32'(txs[k]), 0);
      chk({nm, "_txd"}, 32'(txd[k]), 0);
   endtask

   initial begin
      vec_t tv[11];
      vec_t c1, c2, r7a, r7b;
      int   b0, n;

      rstn = 1'b0;
      drive(0, 1'b0, 0);
      drive(1, 1'b0, 0);
      spur[0] = 1'b0;
      spur[1] = 1'b0;
      dly = 1;

      tv[0]  = mkv("d1543", 0, 1543, 1, 1, 0, "1543\n", 0);
      tv[3]  = mkv("d1000", 0, 1000, 3, 1, 0, "1000\n", 0);
      tv[4]  = mkv("d4095s", 0, 4095, 100, 1, 0, "4095\n", 0);
      tv[5]  = mkv("w12345", 1, 12345, 1, 1, 0, "2345\r\n", 1);
      tv[6]  = mkv("w9999", 1, 9999, 2, 1, 0, "9999\r\n", 0);
      tv[7]  = mkv("w4095inj", 1, 4095, 4, 1, 1, "4095\r\n", 0);
      tv[8]  = mkv("w65535", 1, 65535, 1, 1, 0, "5535\r\n", 1);
`ifdef LEAD_ZERO_BLANK_EN
      tv[1]  = mkv("d0", 0, 0, 2, 1, 0, "0\n", 0);
      tv[2]  = mkv("d40", 0, 40, 1, 0, 0, "40\n", 0);
      tv[9]  = mkv("w10000", 1, 10000, 1, 0, 0, "0\r\n", 1);
      tv[10] = mkv("w1", 1, 1, 1, 0, 0, "1\r\n", 0);
      c1     = mkv("c12", 0, 12, 1, 0, 0, "12\n", 0);
      c2     = mkv("c321", 0, 321, 1, 0, 0, "321\n", 0);
      r7a    = mkv("r7a", 0, 7, 1, 0, 0, "7\n", 0);
      r7b    = mkv("r7b", 1, 7, 1, 0, 0, "7\r\n", 0);
`else
      tv[1]  = mkv("d0", 0, 0, 2, 1, 0, "0000\n", 0);
      tv[2]  = mkv("d40", 0, 40, 1, 1, 0, "0040\n", 0);
      tv[9]  = mkv("w10000", 1, 10000, 1, 1, 0, "0000\r\n", 1);
      tv[10] = mkv("w1", 1, 1, 1, 1, 0, "0001\r\n", 0);
      c1     = mkv("c12", 0, 12, 1, 1, 0, "0012\n", 0);
      c2     = mkv("c321", 0, 321, 1, 1, 0, "0321\n", 0);
      r7a    = mkv("r7a", 0, 7, 1, 1, 0, "0007\n", 0);
      r7b    = mkv("r7b", 1, 7, 1, 1, 0, "0007\r\n", 0);
`endif

      repeat (3) tick();
      chk_reset("rst0", 0);
      chk_reset("rst1", 1);
      rstn = 1'b1;
      repeat (2) tick();

      spur[0] = 1'b1;
      tick();
      spur[0] = 1'b0;
      repeat (3) tick();
      chk("spur_busy", 32'(bsy[0]), 0);
      chk("spur_txs", rxn[0], 0);

      for (int i = 0; i < 11; i++) begin
         run_vec(tv[i], 1'b0, 1'b0, 0);
         tick();
      end

      run_vec(c1, 1'b0, 1'b1, 321);
      run_vec(c2, 1'b1, 1'b0, 0);
      tick();

      dly = 5;
      b0 = rxn[1];
      drive(1, 1'b1, 12345);
      tick();
      drive(1, 1'b0, 0);
      n = 0;
      while (rxn[1] - b0 < 3 && n < 1000) begin
         tick();
         n++;
      end
      chk("midrst_third_byte", rxn[1] - b0, 3);
      tick();
      chk("midrst_ovf_set", 32'(ov[1]), 1);
      rstn = 1'b0;
      tick();
      chk_reset("midrst", 1);
      repeat (2) tick();
      rstn = 1'b1;
      b0 = rxn[1];
      repeat (12) tick();
      chk("midrst_no_bytes", rxn[1] - b0, 0);
      chk("midrst_idle", 32'(bsy[1]), 0);

      run_vec(r7a, 1'b0, 1'b0, 0);
      tick();
      run_vec(r7b, 1'b0, 1'b0, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
